// File: rtl/logicnet_layer_lut_engine.sv
// Time-multiplexed LogicNet layer: N truth-table neurons
// evaluated serially from one shared, programmable LUT RAM.
module logicnet_layer_lut_engine #(
  parameter int N_NEURONS = 8,
  parameter int IN_BITS   = 6,
  parameter int OUT_BITS  = 2,
  localparam int NW = $clog2(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [NW+IN_BITS-1:0]         cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_err,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  output logic                          busy
);

  localparam int AW    = NW + IN_BITS;
  localparam int IW    = N_NEURONS * IN_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t              state;
  logic [NW-1:0]       cnt;
  logic [IW-1:0]       in_reg;
  logic [IN_BITS-1:0]  sel;
  logic [AW-1:0]       rd_addr;
  logic [OUT_BITS-1:0] rd_q;
  logic [NW-1:0]       rd_slot;
  logic                rd_vld;
  logic                accept;
  logic                idx_ok;
  logic                cfg_ok;
  logic [OUT_BITS-1:0] ram [DEPTH];

  assign accept = (state == IDLE) && in_valid;
  assign idx_ok = {1'b0, cfg_addr[AW-1 -: NW]}
                < (NW+1)'(N_NEURONS);
  assign cfg_ok = cfg_we && (state == IDLE)
                && !in_valid && idx_ok;

  // fan-in slice of the neuron currently being issued
  always_comb begin
    sel = in_reg[IN_BITS-1:0];
    for (int k = 0; k < N_NEURONS; k++) begin
      if (cnt == NW'(k))
        sel = in_reg[k*IN_BITS +: IN_BITS];
    end
  end

  assign rd_addr = {cnt, sel};

  // shared LUT RAM: config write port, registered read port
  always_ff @(posedge clk) begin
    if (cfg_ok)
      ram[cfg_addr] <= cfg_data;
    rd_q <= ram[rd_addr];
  end

  // sequencing FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_reg    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            in_reg   <= in_data;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == NW'(N_NEURONS-1))
            state <= DRAIN;
          else
            cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // drop read data into its result slot; flag rejected writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      rd_slot  <= '0;
      out_data <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      rd_vld  <= (state == RUN);
      rd_slot <= cnt;
      if (rd_vld) begin
        for (int k = 0; k < N_NEURONS; k++) begin
          if (rd_slot == NW'(k))
            out_data[k*OUT_BITS +: OUT_BITS] <= rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_logicnet_layer_lut_engine.sv
// Directed bench for logicnet_layer_lut_engine.
// Second small instance covers the bad-index path.
module tb_logicnet_layer_lut_engine;

  localparam int N  = 8;
  localparam int IB = 6;
  localparam int OB = 2;
  localparam int NW = 3;
  localparam int IW = N * IB;
  localparam int OW = N * OB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [NW+IB-1:0] cfg_addr = '0;
  logic [OB-1:0] cfg_data = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          busy;

  logic          cfg_we6 = 1'b0;
  logic [8:0]    cfg_addr6 = '0;
  logic [1:0]    cfg_data6 = '0;
  logic          cfg_err6;
  logic          in_ready6;
  logic [35:0]   in_data6 = '0;
  logic          out_valid6;
  logic [11:0]   out_data6;
  logic          busy6;

  int errors = 0;
  int checks = 0;
  logic [1:0] lut [N][64];

  always #5 clk = ~clk;

  logicnet_layer_lut_engine u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  logicnet_layer_lut_engine #(.N_NEURONS(6)) u6 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we6), .cfg_addr(cfg_addr6),
    .cfg_data(cfg_data6), .cfg_err(cfg_err6),
    .in_valid(1'b0), .in_ready(in_ready6),
    .in_data(in_data6), .out_valid(out_valid6),
    .out_ready(1'b0), .out_data(out_data6),
    .busy(busy6)
  );

  function automatic logic [OW-1:0] model(
    input logic [IW-1:0] d);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      r[k*OB +: OB] = lut[k][d[k*IB +: IB]];
    return r;
  endfunction

  function automatic logic [IW-1:0] rnd();
    return IW'({$urandom, $urandom});
  endfunction

  task automatic cfg_write(input int k, input int p,
                           input logic [1:0] v);
    cfg_we   = 1'b1;
    cfg_addr = {NW'(k), IB'(p)};
    cfg_data = v;
    lut[k][p] = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send_vec(input logic [IW-1:0] d,
                          output int lat);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n - 1;
  endtask

  task automatic finish_vec();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL rst_out_data got=%h want=0", out_data);
    end
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_err_busy got=%b%b want=00",
               cfg_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 64; p++)
        cfg_write(k, p, 2'b00);
    cfg_write(0, 8, 2'b11);
    cfg_write(0, 4, 2'b01);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_write_err got=%b want=0", cfg_err);
    end
    send_vec(IW'(6'b001000), lat);
    checks++;
    if (out_data !== 16'h0003) begin
      errors++;
      $display("FAIL basic_a got=%h want=0003", out_data);
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_lat got=%0d want=9", lat);
    end
    finish_vec();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_ret got=%b want=01",
               {out_valid, in_ready});
    end
    send_vec(IW'(6'b000100), lat);
    checks++;
    if (out_data !== 16'h0001) begin
      errors++;
      $display("FAIL basic_b got=%h want=0001", out_data);
    end
    finish_vec();
  endtask

  task automatic test_table();
    int lat;
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 64; p++)
        cfg_write(k, p, 2'(k));
    send_vec(rnd(), lat);
    checks++;
    if (out_data !== 16'hE4E4) begin
      errors++;
      $display("FAIL table got=%h want=e4e4", out_data);
    end
    checks++;
    if (lat !== 9 || busy !== 1'b1) begin
      errors++;
      $display("FAIL table_lat got=%0d/%b want=9/1",
               lat, busy);
    end
    finish_vec();
  endtask

  task automatic test_backpressure();
    int lat;
    send_vec(rnd(), lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_data}
          !== {1'b1, 1'b0, 16'hE4E4}) begin
        errors++;
        $display("FAIL hold%0d got=%b%b/%h want=10/e4e4",
                 i, out_valid, in_ready, out_data);
      end
    end
    finish_vec();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL release got=%b want=010",
               {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_cfg_collide();
    int n;
    int lat;
    in_valid = 1'b1;
    in_data  = IW'(6'd5) << (2*IB);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = {3'd2, 6'd5};
    cfg_data = 2'b00;
    @(negedge clk);
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL run_err got=%b want=1", cfg_err);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL run_err_pulse got=%b want=0", cfg_err);
    end
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    finish_vec();
    send_vec(IW'(6'd5) << (2*IB), lat);
    checks++;
    if (out_data !== 16'hE4E4) begin
      errors++;
      $display("FAIL run_drop got=%h want=e4e4", out_data);
    end
    finish_vec();
    in_valid = 1'b1;
    in_data  = IW'(6'd9) << IB;
    cfg_we   = 1'b1;
    cfg_addr = {3'd1, 6'd9};
    cfg_data = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    checks++;
    if ({cfg_err, busy} !== 2'b11) begin
      errors++;
      $display("FAIL idle_collide got=%b want=11",
               {cfg_err, busy});
    end
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    finish_vec();
    send_vec(IW'(6'd9) << IB, lat);
    checks++;
    if (out_data !== 16'hE4E4) begin
      errors++;
      $display("FAIL collide_drop got=%h want=e4e4",
               out_data);
    end
    finish_vec();
  endtask

  task automatic test_bad_index();
    cfg_we6   = 1'b1;
    cfg_addr6 = {3'd7, 6'd0};
    @(negedge clk);
    checks++;
    if (cfg_err6 !== 1'b1) begin
      errors++;
      $display("FAIL idx7_err got=%b want=1", cfg_err6);
    end
    cfg_addr6 = {3'd6, 6'd0};
    @(negedge clk);
    checks++;
    if (cfg_err6 !== 1'b1) begin
      errors++;
      $display("FAIL idx6_err got=%b want=1", cfg_err6);
    end
    cfg_addr6 = {3'd5, 6'd0};
    @(negedge clk);
    cfg_we6 = 1'b0;
    checks++;
    if (cfg_err6 !== 1'b0) begin
      errors++;
      $display("FAIL idx5_err got=%b want=0", cfg_err6);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    in_data  = rnd();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, cfg_err} !== 4'b1000
        || out_data !== '0) begin
      errors++;
      $display("FAIL mid_rst got=%b/%h want=1000/0000",
               {in_ready, out_valid, busy, cfg_err},
               out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_vec(rnd(), lat);
    checks++;
    if (out_data !== 16'hE4E4 || lat !== 9) begin
      errors++;
      $display("FAIL post_rst got=%h/%0d want=e4e4/9",
               out_data, lat);
    end
    finish_vec();
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] q[$];
    logic [OW-1:0] exp_v;
    int sent;
    int got;
    int cyc;
    int last;
    int badgap;
    sent = 0;
    got = 0;
    cyc = 0;
    last = -1;
    badgap = 0;
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 64; p++)
        cfg_write(k, p, 2'($urandom_range(0, 3)));
    out_ready = 1'b1;
    in_data   = rnd();
    in_valid  = 1'b1;
    while (got < 200 && cyc < 3000) begin
      if (in_ready) begin
        if (sent < 200) begin
          q.push_back(model(in_data));
          if (last >= 0 && cyc - last != N + 3)
            badgap++;
          last = cyc;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        in_data = rnd();
      end
      if (out_valid) begin
        checks++;
        exp_v = 'x;
        if (q.size() > 0)
          exp_v = q.pop_front();
        if (out_data !== exp_v) begin
          errors++;
          $display("FAIL b2b%0d got=%h want=%h",
                   got, out_data, exp_v);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got !== 200) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=200", got);
    end
    checks++;
    if (badgap !== 0) begin
      errors++;
      $display("FAIL b2b_period got=%0d bad want=0",
               badgap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_table();
    test_backpressure();
    test_cfg_collide();
    test_bad_index();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
